// File: rtl/i2c_ccd_target.sv
// I2C target for the camera-register protocol: 7-bit device address, 8-bit
// register pointer, 16-bit MSB-first words, open-drain SDA, no clock stretching.
module i2c_ccd_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h5D,
  parameter int         SYNC_STAGES = 2,
  parameter int         AUTO_INC    = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        I2C_SCLK,
  inout  wire         I2C_SDAT,
  output logic [7:0]  oREG_ADDR,
  output logic [15:0] oREG_WDATA,
  output logic        oREG_WE,
  output logic        oREG_RE,
  input  logic [15:0] iREG_RDATA,
  output logic        oBUSY
);
  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, PTR, ACK_PTR, WR_MSB, ACK_MSB, WR_LSB, ACK_LSB,
    RD_MSB, MACK_MSB, RD_LSB, MACK_LSB, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic        scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sr_q, sr_d, msb_q, msb_d, ptr_q, ptr_d;
  logic [15:0] rd_word_q, rd_word_d, wdata_q, wdata_d;
  logic        rw_q, rw_d, mack_q, mack_d;
  logic        we_q, we_d, re_q, re_d, re_dly_q, re_dly_d;
  logic        busy_q, busy_d, sda_oe_q, sda_oe_d;

  logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic        byte_done, last_bit, addr_hit, rd_bit;
  logic [7:0]  sr_in;
  logic [3:0]  rd_idx;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s && !scl_prev_q;
  assign scl_fall  = !scl_s && scl_prev_q;
  assign start_det = scl_s && scl_prev_q && sda_prev_q && !sda_s;
  assign stop_det  = scl_s && scl_prev_q && !sda_prev_q && sda_s;
  assign byte_done = (bit_cnt_q == 4'd8);
  assign last_bit  = (bit_cnt_q == 4'd7);
  assign sr_in     = {sr_q[6:0], sda_s};
  assign addr_hit  = (sr_q[7:1] == DEV_ADDR) && (sr_q[7:1] != 7'd0);
  // Bit k of a read byte (k = bits already clocked) is word bit 7-k, +8 for the MSB byte.
  assign rd_idx    = {state_q == RD_MSB, ~bit_cnt_q[2:0]};
  assign rd_bit    = rd_word_q[rd_idx];

  assign I2C_SDAT   = sda_oe_q ? 1'b0 : 1'bz;
  assign oREG_ADDR  = ptr_q;
  assign oREG_WDATA = wdata_q;
  assign oREG_WE    = we_q;
  assign oREG_RE    = re_q;
  assign oBUSY      = busy_q;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    msb_d      = msb_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    mack_d     = mack_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    re_dly_d   = re_q;
    rd_word_d  = re_dly_q ? iREG_RDATA : rd_word_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;

    // START wins over everything, including a bit sampled in the same cycle.
    if (start_det) begin
      state_d   = DEVADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: sda_oe_d = 1'b0;
        IGNORE: sda_oe_d = 1'b0;
        DEVADDR, PTR, WR_MSB, WR_LSB: begin
          if (scl_rise && !byte_done) begin
            sr_d      = sr_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit && state_q == PTR) ptr_d = sr_in;
            if (last_bit && state_q == WR_LSB) begin
              we_d    = 1'b1;
              wdata_d = {msb_q, sr_in};
            end
          end else if (scl_fall && byte_done) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            case (state_q)
              DEVADDR: begin
                if (addr_hit) begin
                  state_d = ACK_DEV;
                  busy_d  = 1'b1;
                  rw_d    = sr_q[0];
                  re_d    = sr_q[0];
                end else begin
                  state_d  = IGNORE;
                  sda_oe_d = 1'b0;
                end
              end
              PTR: state_d = ACK_PTR;
              WR_MSB: begin
                msb_d   = sr_q;
                state_d = ACK_MSB;
              end
              default: begin
                state_d = ACK_LSB;
                if (AUTO_INC != 0) ptr_d = ptr_q + 8'd1;
              end
            endcase
          end
        end
        ACK_DEV: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = RD_MSB;
              sda_oe_d = !rd_word_q[15];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        ACK_PTR, ACK_LSB: begin
          if (scl_fall) begin
            state_d   = WR_MSB;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end
        end
        ACK_MSB: begin
          if (scl_fall) begin
            state_d   = WR_LSB;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
          end
        end
        RD_MSB, RD_LSB: begin
          if (scl_rise && !byte_done) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (byte_done) begin
              state_d   = (state_q == RD_MSB) ? MACK_MSB : MACK_LSB;
              bit_cnt_d = 4'd0;
              sda_oe_d  = 1'b0;
              mack_d    = 1'b0;
            end else begin
              sda_oe_d = !rd_bit;
            end
          end
        end
        MACK_MSB: begin
          if (scl_fall) begin
            state_d  = RD_LSB;
            sda_oe_d = !rd_word_q[7];
          end
        end
        MACK_LSB: begin
          if (scl_rise) begin
            mack_d = !sda_s;
            if (!sda_s) begin
              re_d = 1'b1;
              if (AUTO_INC != 0) ptr_d = ptr_q + 8'd1;
            end
          end else if (scl_fall) begin
            if (mack_q) begin
              state_d  = RD_MSB;
              sda_oe_d = !rd_word_q[15];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      sr_q       <= 8'd0;
      msb_q      <= 8'd0;
      ptr_q      <= 8'd0;
      wdata_q    <= 16'd0;
      rd_word_q  <= 16'd0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      re_dly_q   <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      msb_q      <= msb_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      rd_word_q  <= rd_word_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
      we_q       <= we_d;
      re_q       <= re_d;
      re_dly_q   <= re_dly_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_ccd_target.sv
// Bench for i2c_ccd_target: a bit-banged master drives the bus while a
// transaction-level model predicts register writes, reads and the pointer.
`timescale 1ns/1ps
module tb_i2c_ccd_target;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  wire         sda_bus;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy;

  logic [15:0] mem [256];
  logic [7:0]  model_ptr;
  int          checks = 0;
  int          errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] we_log[$];
  logic [7:0]  exp_re_q[$];
  logic [7:0]  re_log[$];
  bit          dut_low_seen, busy_seen;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);
  assign reg_rdata = mem[reg_addr];

  i2c_ccd_target #(.DEV_ADDR(7'h5D), .SYNC_STAGES(2), .AUTO_INC(1)) dut (
    .iCLK(clk), .iRST(rst), .I2C_SCLK(scl), .I2C_SDAT(sda_bus),
    .oREG_ADDR(reg_addr), .oREG_WDATA(reg_wdata), .oREG_WE(reg_we),
    .oREG_RE(reg_re), .iREG_RDATA(reg_rdata), .oBUSY(busy)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---- bus monitor ----
  always @(posedge clk) begin
    #1;
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (m_sda && sda_bus === 1'b0) dut_low_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_clk(5);
    scl = 1'b1;   wait_clk(10);
    m_sda = 1'b0; wait_clk(10);
    scl = 1'b0;   wait_clk(5);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clk(5);
    scl = 1'b1;   wait_clk(10);
    m_sda = 1'b1; wait_clk(10);
  endtask

  task automatic write_bit(input bit b);
    m_sda = b; wait_clk(5);
    scl = 1'b1; wait_clk(10);
    scl = 1'b0; wait_clk(5);
  endtask

  task automatic read_bit(output bit b);
    m_sda = 1'b1; wait_clk(5);
    scl = 1'b1;   wait_clk(5);
    b = sda_bus;  wait_clk(5);
    scl = 1'b0;   wait_clk(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = !b;
  endtask

  task automatic read_byte(input bit mack, output logic [7:0] d);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(!mack);
  endtask

  // ---- scoreboard ----
  task automatic compare_logs(input string tag);
    logic [23:0] g;
    logic [7:0]  ga;
    check({tag, " we_count"}, we_log.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      g = (we_log.size() > 0) ? we_log.pop_front() : 24'hxxxxxx;
      check({tag, " we"}, g, exp_q.pop_front());
    end
    check({tag, " re_count"}, re_log.size(), exp_re_q.size());
    while (exp_re_q.size() > 0) begin
      ga = (re_log.size() > 0) ? re_log.pop_front() : 8'hxx;
      check({tag, " re_addr"}, ga, exp_re_q.pop_front());
    end
    we_log.delete();
    re_log.delete();
    check({tag, " ptr"}, reg_addr, model_ptr);
  endtask

  // Write transaction: pointer then data bytes; only complete pairs produce writes.
  task automatic do_write(input string tag, input logic [7:0] ptr, input logic [7:0] data_bytes[$]);
    bit ack;
    logic [7:0] p;
    p = ptr;
    bus_start();
    write_byte(8'hBA, ack); check({tag, " ack_dev"}, ack, 1);
    write_byte(ptr, ack);   check({tag, " ack_ptr"}, ack, 1);
    for (int i = 0; i < data_bytes.size(); i++) begin
      write_byte(data_bytes[i], ack);
      check({tag, " ack_data"}, ack, 1);
      if (i % 2 == 1) begin
        exp_q.push_back({p, data_bytes[i-1], data_bytes[i]});
        mem[p] = {data_bytes[i-1], data_bytes[i]};
        p = p + 8'd1;
      end
    end
    check({tag, " busy_mid"}, busy, 1);
    bus_stop();
    check({tag, " busy_end"}, busy, 0);
    model_ptr = p;
    compare_logs(tag);
  endtask

  // Read transaction: set pointer, repeated START, read n words, NACK the last.
  task automatic do_read(input string tag, input logic [7:0] ptr, input int n);
    bit ack;
    logic [7:0] d, a;
    bus_start();
    write_byte(8'hBA, ack); check({tag, " ack_dev_w"}, ack, 1);
    write_byte(ptr, ack);   check({tag, " ack_ptr"}, ack, 1);
    bus_start();
    write_byte(8'hBB, ack); check({tag, " ack_dev_r"}, ack, 1);
    for (int w = 0; w < n; w++) begin
      a = ptr + 8'(w);
      exp_re_q.push_back(a);
      read_byte(1'b1, d);
      check({tag, " msb"}, d, mem[a][15:8]);
      dut_low_seen = 1'b0;
      read_byte(w != n - 1, d);
      check({tag, " lsb"}, d, mem[a][7:0]);
    end
    dut_low_seen = 1'b0;
    wait_clk(10);
    check({tag, " sda_after_nack"}, dut_low_seen, 0);
    bus_stop();
    check({tag, " busy_end"}, busy, 0);
    model_ptr = ptr + 8'(n - 1);
    compare_logs(tag);
  endtask

  logic [7:0] bq[$];
  bit         ack;
  int         op, nb, nw;
  logic [7:0] rp;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom());
    model_ptr = 8'h00;

    // ---- reset ----
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    check("rst addr", reg_addr, 0);
    check("rst wdata", reg_wdata, 0);
    check("rst we", reg_we, 0);
    check("rst re", reg_re, 0);
    check("rst busy", busy, 0);
    check("rst sda", sda_bus, 1);

    // ---- directed ----
    bq.delete(); bq.push_back(8'h01); bq.push_back(8'h00);
    do_write("wr09", 8'h09, bq);

    bq.delete(); bq.push_back(8'h00); bq.push_back(8'h00); bq.push_back(8'h11); bq.push_back(8'h11);
    do_write("wr20", 8'h20, bq);
    check("wr20 final_ptr", reg_addr, 8'h22);

    mem[8'h09] = 16'h1234;
    do_read("rd09", 8'h09, 1);

    dut_low_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    write_byte(8'hB8, ack); check("nomatch ack_dev", ack, 0);
    for (int i = 0; i < 3; i++) begin
      write_byte(8'($urandom_range(0, 255)), ack);
      check("nomatch ack_data", ack, 0);
    end
    bus_stop();
    check("nomatch sda_low", dut_low_seen, 0);
    check("nomatch busy", busy_seen, 0);
    compare_logs("nomatch");

    bq.delete(); bq.push_back(8'h00);
    do_write("wr05_partial", 8'h05, bq);
    check("wr05 ptr", reg_addr, 8'h05);

    bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h5A); bq.push_back(8'h3C); bq.push_back(8'hC3);
    do_write("wrap", 8'hFF, bq);

    // ---- reset during a driven read bit ----
    mem[8'h05] = 16'h0F00;
    bus_start();
    write_byte(8'hBA, ack);
    write_byte(8'h05, ack);
    bus_start();
    write_byte(8'hBB, ack);
    check("rstmid ack_dev_r", ack, 1);
    wait_clk(1);
    check("rstmid bit_driven", sda_bus, 0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("rstmid sda", sda_bus, 1);
    check("rstmid addr", reg_addr, 0);
    check("rstmid we", reg_we, 0);
    check("rstmid re", reg_re, 0);
    check("rstmid busy", busy, 0);
    check("rstmid wdata", reg_wdata, 0);
    bus_stop();
    model_ptr = 8'h00;
    we_log.delete();
    re_log.delete();

    // ---- randomized transactions ----
    for (int t = 0; t < 12; t++) begin
      op = $urandom_range(0, 1);
      rp = ($urandom_range(0, 3) == 0) ? 8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
      if (op == 0) begin
        nb = $urandom_range(0, 6);
        bq.delete();
        for (int i = 0; i < nb; i++) bq.push_back(8'($urandom_range(0, 255)));
        do_write("rnd_wr", rp, bq);
      end else begin
        nw = $urandom_range(1, 3);
        do_read("rnd_rd", rp, nw);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_ccd_target.md
Name: i2c_ccd_target

Overview:
- I2C responder (target) for the camera-register protocol: 7-bit device address, 8-bit register pointer, 16-bit MSB-first data words.
- It is the other end of the sensor-configuration master. Used as a sensor model in simulation and as an FPGA-side register port, so the on-chip register bank can be written and read over the same bus.
- Decodes START, STOP, repeated START, device address, pointer and data bytes.
- Issues one-cycle register write/read strobes and drives ACKs and read data on SDA (open-drain).

Parameters:
- DEV_ADDR, 7'h5D, 7-bit target address; the write byte is 0xBA and the read byte is 0xBB.
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on SCL and on SDA input (minimum 2).
- AUTO_INC, 1, when 1 the pointer increments after each completed 16-bit word; when 0 it holds.

Ports:
- iCLK  in  1  system clock; all logic is on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- I2C_SCLK  in  1  bus clock. This block never drives SCL (no clock stretching).
- I2C_SDAT  inout  1  bus data line, open-drain: driven 1'b0 or 1'bz only.
- oREG_ADDR  out  8  current register pointer.
- oREG_WDATA  out  16  assembled write word; valid while oREG_WE=1.
- oREG_WE  out  1  one-cycle write strobe.
- oREG_RE  out  1  one-cycle read request.
- iREG_RDATA  in  16  read word; sampled on the iCLK cycle after oREG_RE.
- oBUSY  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset: all outputs are 0, SDA is released (z), pointer = 0x00, state = IDLE. Reset asserted mid-transfer releases SDA on the next iCLK.
- Synchronizer: SCL and SDA pass through SYNC_STAGES flip-flops, then a 1-cycle edge detect.
  - The bus is legal only if each SCL high and low phase lasts at least 8 iCLK cycles.
- Bus conditions:
  - START = SDA falling while SCL is high. STOP = SDA rising while SCL is high.
  - Data bits are sampled on SCL rising edges. The SDA drive changes 1 iCLK after an SCL falling edge.
- States: IDLE, DEVADDR, ACK_DEV, PTR, ACK_PTR, WR_MSB, ACK_MSB, WR_LSB, ACK_LSB, RD_MSB, MACK_MSB, RD_LSB, MACK_LSB, IGNORE.
- Any START or repeated START, in any state: go to DEVADDR, clear the bit counter, release SDA.
- STOP, in any state: go to IDLE, release SDA, oBUSY=0; the pointer is retained.
- DEVADDR, after 8 bits:
  - bits[7:1]==DEV_ADDR: go to ACK_DEV and pull SDA low for that ACK clock.
  - Address 0x00 (general call) or any mismatch: go to IGNORE; SDA is never driven in IGNORE.
- Write path:
  - ACK_DEV with R/W=0 goes to PTR. The byte is loaded into the pointer, then ACK_PTR, then WR_MSB.
  - WR_MSB, then ACK_MSB, then WR_LSB.
  - At the 8th LSB bit sample: oREG_WE=1 for exactly 1 iCLK with the pre-increment oREG_ADDR.
  - Then ACK_LSB, the pointer increments if AUTO_INC, and the state returns to WR_MSB.
- Read path:
  - ACK_DEV with R/W=1: oREG_RE pulses in the ACK_DEV cycle, and iREG_RDATA is captured into the shift register 1 cycle later.
  - MSB then LSB are shifted out MSB-first. Only 0 bits pull SDA low; 1 bits release it.
  - After each byte SDA is released for the master's ACK.
  - MACK_MSB always continues to RD_LSB.
  - MACK_LSB, ACK (SDA low): pointer++ if AUTO_INC, oREG_RE pulses, next word is fetched, go to RD_MSB.
  - MACK_LSB, NACK: go to IGNORE until STOP or START.
- Partial transfers:
  - STOP or START after the MSB only: no oREG_WE, pointer unchanged.
  - STOP right after the pointer byte: pointer is set, no write.
- Pointer wraps 0xFF to 0x00.
- A START detected in the same cycle as a bit sample takes priority; the bit is discarded.

Test Plan:
- Write BA,09,01,00,STOP → ACK on all 4 bytes; one oREG_WE with addr 0x09, data 0x0100; oBUSY falls at STOP.
- Write BA,20,00,00,11,11,STOP (AUTO_INC=1) → WE addr 0x20 data 0x0000, then WE addr 0x21 data 0x1111; final pointer 0x22.
- Read BA,09,Sr,BB with iREG_RDATA=0x1234, master ACK then NACK → oREG_RE with addr 0x09; bus bytes 0x12,0x34; SDA released after the NACK.
- Address byte 0xB8 then 3 data bytes → SDA never driven low, no WE/RE, oBUSY stays 0.
- Write BA,05,00,STOP → pointer=0x05, no oREG_WE.
- iRST=1 for 1 cycle while driving a read bit 0 → SDA is z next cycle, all outputs 0, pointer 0x00.
